// File: rtl/poly_dec_fir_if.sv
// Bus bundle for poly_dec_fir: sample input, coefficient write port and
// filter output, each with its own handshake.
interface poly_dec_fir_if #(
   parameter int unsigned WIN   = 8,
   parameter int unsigned WCOEF = 10,
   parameter int unsigned WOUT  = 20,
   parameter int unsigned AW    = 5
);
   logic signed [WIN-1:0]   in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic                    coef_we;
   logic [AW-1:0]           coef_addr;
   logic signed [WCOEF-1:0] coef_data;
   logic                    coef_busy;
   logic signed [WOUT-1:0]  out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_sat;

   modport master (
      output in_data, in_valid, coef_we, coef_addr, coef_data, out_ready,
      input  in_ready, coef_busy, out_data, out_valid, out_sat
   );

   modport slave (
      input  in_data, in_valid, coef_we, coef_addr, coef_data, out_ready,
      output in_ready, coef_busy, out_data, out_valid, out_sat
   );
endinterface

// File: rtl/poly_dec_fir.sv
// Runtime-programmable decimating FIR with one time-multiplexed MAC.
// Define POLY_FIR_SAT_EN to clamp out-of-range results instead of wrapping.
module poly_dec_fir #(
   parameter int unsigned WIN   = 8,
   parameter int unsigned WCOEF = 10,
   parameter int unsigned TAPS  = 21,
   parameter int unsigned DEC   = 4,
   parameter int unsigned SHIFT = 0,
   parameter int unsigned WOUT  = 20
) (
   input logic          clk,
   input logic          reset,
   poly_dec_fir_if.slave bus
);
   localparam int unsigned AW    = $clog2(TAPS);
   localparam int unsigned PW    = (DEC > 1) ? $clog2(DEC) : 1;
   localparam int unsigned WPROD = WIN + WCOEF;
   localparam int unsigned WACC  = WIN + WCOEF + $clog2(TAPS);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t state, state_n;

   logic signed [WIN-1:0]   x [TAPS];
   logic signed [WCOEF-1:0] c [TAPS];
   logic [PW-1:0]           phase;
   logic [AW-1:0]           tap;
   logic signed [WACC-1:0]  acc;

   logic                    in_ready_q;
   logic                    coef_busy_q;
   logic signed [WOUT-1:0]  out_data_q;
   logic                    out_valid_q;
   logic                    out_sat_q;

   logic                    accept_c;
   logic                    start_c;
   logic                    mac_c;
   logic                    last_tap_c;
   logic                    load_c;
   logic                    hs_c;
   logic                    coef_wr_c;
   logic signed [WPROD-1:0] prod_c;
   logic signed [WOUT-1:0]  res_c;
   logic                    sat_c;

   assign bus.in_ready  = in_ready_q;
   assign bus.coef_busy = coef_busy_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sat   = out_sat_q;

   assign last_tap_c = (tap == AW'(TAPS - 1));
   assign prod_c     = x[tap] * c[tap];
   assign coef_wr_c  = bus.coef_we && !coef_busy_q && (32'(bus.coef_addr) < TAPS);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state and datapath strobes
   always_comb begin
      state_n  = state;
      accept_c = 1'b0;
      start_c  = 1'b0;
      mac_c    = 1'b0;
      load_c   = 1'b0;
      hs_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               accept_c = 1'b1;
               if (phase == PW'(DEC - 1)) begin
                  start_c = 1'b1;
                  state_n = MAC;
               end
            end
         end
         MAC: begin
            mac_c = 1'b1;
            if (last_tap_c) state_n = OUT;
         end
         OUT: begin
            // out_valid low in OUT means this is the entry cycle
            if (!out_valid_q) begin
               load_c = 1'b1;
            end else if (bus.out_ready) begin
               hs_c    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Sample delay line, x[0] newest
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(TAPS); i++) x[i] <= '0;
      end else if (accept_c) begin
         x[0] <= bus.in_data;
         for (int i = 1; i < int'(TAPS); i++) x[i] <= x[i-1];
      end
   end

   // Coefficient register file
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(TAPS); i++) c[i] <= '0;
      end else if (coef_wr_c) begin
         c[bus.coef_addr] <= bus.coef_data;
      end
   end

   // Phase counter, tap counter and accumulator
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
         tap   <= '0;
         acc   <= '0;
      end else begin
         if (accept_c) phase <= start_c ? '0 : phase + PW'(1);
         if (start_c) begin
            acc <= '0;
            tap <= '0;
         end else if (mac_c) begin
            acc <= acc + WACC'(prod_c);
            tap <= last_tap_c ? '0 : tap + AW'(1);
         end
      end
   end

`ifdef POLY_FIR_SAT_EN
   localparam logic signed [WOUT-1:0] OUT_MAX = {1'b0, {(WOUT-1){1'b1}}};
   localparam logic signed [WOUT-1:0] OUT_MIN = {1'b1, {(WOUT-1){1'b0}}};

   logic signed [WACC-1:0] r_c;
   logic                   ovf_c;

   assign r_c = acc >>> SHIFT;

   // Out of range when the bits above the output sign disagree with it
   if (WOUT >= WACC) begin : g_fit
      assign ovf_c = 1'b0;
   end else begin : g_clip
      assign ovf_c = (r_c[WACC-1:WOUT-1] != {(WACC-WOUT+1){r_c[WACC-1]}});
   end

   assign res_c = ovf_c ? (r_c[WACC-1] ? OUT_MIN : OUT_MAX) : WOUT'(r_c);
   assign sat_c = ovf_c;
`else
   assign res_c = WOUT'(acc >>> SHIFT);
   assign sat_c = 1'b0;
`endif

   // Registered outputs and handshake flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready_q  <= 1'b1;
         coef_busy_q <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         in_ready_q  <= (state_n == IDLE);
         coef_busy_q <= (state_n == MAC);
         if (load_c) begin
            out_data_q  <= res_c;
            out_sat_q   <= sat_c;
            out_valid_q <= 1'b1;
         end else if (hs_c) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_poly_dec_fir.sv
// Directed + randomized bench for poly_dec_fir: two instances (DEC=4/WOUT=20
// and DEC=1/WOUT=8) checked against an arithmetic reference model.
module tb_poly_dec_fir;
   localparam int unsigned WIN   = 8;
   localparam int unsigned WCOEF = 10;
   localparam int unsigned TAPS  = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned SHIFT = 0;
   localparam int unsigned DEC0  = 4;
   localparam int unsigned WOUT0 = 20;
   localparam int unsigned DEC1  = 1;
   localparam int unsigned WOUT1 = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   poly_dec_fir_if #(.WIN(WIN), .WCOEF(WCOEF), .WOUT(WOUT0), .AW(AW)) b0 ();
   poly_dec_fir_if #(.WIN(WIN), .WCOEF(WCOEF), .WOUT(WOUT1), .AW(AW)) b1 ();

   poly_dec_fir #(.WIN(WIN), .WCOEF(WCOEF), .TAPS(TAPS), .DEC(DEC0),
                  .SHIFT(SHIFT), .WOUT(WOUT0))
      u0 (.clk(clk), .reset(reset), .bus(b0.slave));

   poly_dec_fir #(.WIN(WIN), .WCOEF(WCOEF), .TAPS(TAPS), .DEC(DEC1),
                  .SHIFT(SHIFT), .WOUT(WOUT1))
      u1 (.clk(clk), .reset(reset), .bus(b1.slave));

   int     n_checks = 0;
   int     n_fail   = 0;
   int     hx [2][TAPS];
   int     hc [2][TAPS];
   int     cnt [2];
   longint exp0 [$];
   longint exp1 [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp_v), exp_v);
      end
   endtask

   function automatic logic rdy(input int u);
      return (u == 0) ? b0.in_ready : b1.in_ready;
   endfunction
   function automatic logic ov(input int u);
      return (u == 0) ? b0.out_valid : b1.out_valid;
   endfunction
   function automatic logic os(input int u);
      return (u == 0) ? b0.out_sat : b1.out_sat;
   endfunction
   function automatic logic cbusy(input int u);
      return (u == 0) ? b0.coef_busy : b1.coef_busy;
   endfunction
   function automatic logic [31:0] od(input int u);
      if (u == 0) return 32'(b0.out_data);
      return 32'(b1.out_data);
   endfunction

   // Reference: y = sum c[k]*x[k], r = y >>> SHIFT, then clamp or wrap to wout bits
   function automatic void narrow(input longint y, input int wout,
                                  output logic [31:0] d, output logic s);
      longint r;
      longint mx;
      longint mn;
      r  = y >>> SHIFT;
      mx = (longint'(1) <<< (wout - 1)) - 1;
      mn = -(longint'(1) <<< (wout - 1));
      s  = 1'b0;
`ifdef POLY_FIR_SAT_EN
      if (r > mx) begin
         r = mx;
         s = 1'b1;
      end else if (r < mn) begin
         r = mn;
         s = 1'b1;
      end
`else
      r = r & ((longint'(1) <<< wout) - 1);
      if (r > mx) r = r - (longint'(1) <<< wout);
`endif
      d = 32'(r);
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         cnt[u] = 0;
         for (int k = 0; k < int'(TAPS); k++) begin
            hx[u][k] = 0;
            hc[u][k] = 0;
         end
      end
      exp0.delete();
      exp1.delete();
   endtask

   task automatic model_push(input int u, input int d);
      longint y;
      int     dec;
      for (int k = int'(TAPS) - 1; k > 0; k--) hx[u][k] = hx[u][k-1];
      hx[u][0] = d;
      cnt[u]++;
      dec = (u == 0) ? int'(DEC0) : int'(DEC1);
      if (cnt[u] % dec == 0) begin
         y = 0;
         for (int k = 0; k < int'(TAPS); k++) y += longint'(hc[u][k]) * longint'(hx[u][k]);
         if (u == 0) exp0.push_back(y);
         else        exp1.push_back(y);
      end
   endtask

   task automatic send(input int u, input int d);
      int n;
      n = 0;
      if (u == 0) begin
         b0.in_data  = WIN'(d);
         b0.in_valid = 1'b1;
      end else begin
         b1.in_data  = WIN'(d);
         b1.in_valid = 1'b1;
      end
      while (rdy(u) !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", 32'(rdy(u)), 32'd1);
      @(posedge clk); #1;
      if (u == 0) b0.in_valid = 1'b0;
      else        b1.in_valid = 1'b0;
      model_push(u, d);
   endtask

   task automatic wcoef(input int u, input int a, input int v, input bit honoured);
      if (u == 0) begin
         b0.coef_we = 1'b1; b0.coef_addr = AW'(a); b0.coef_data = WCOEF'(v);
      end else begin
         b1.coef_we = 1'b1; b1.coef_addr = AW'(a); b1.coef_data = WCOEF'(v);
      end
      @(posedge clk); #1;
      b0.coef_we = 1'b0;
      b1.coef_we = 1'b0;
      if (honoured) hc[u][a] = v;
   endtask

   task automatic get(input int u, input int hold, output int lat, output int busy_n);
      longint      y;
      logic [31:0] ed;
      logic        es;
      logic [31:0] held;
      int          n;
      int          qs;
      y  = 0;
      qs = (u == 0) ? exp0.size() : exp1.size();
      chk("model_has_output", 32'(qs > 0), 32'd1);
      if (qs > 0) y = (u == 0) ? exp0.pop_front() : exp1.pop_front();
      narrow(y, (u == 0) ? int'(WOUT0) : int'(WOUT1), ed, es);
      n      = 0;
      busy_n = int'(cbusy(u));
      while (ov(u) !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
         busy_n += int'(cbusy(u));
      end
      lat = n;
      chk("out_valid_rise", 32'(ov(u)), 32'd1);
      chk("out_data", od(u), ed);
      chk("out_sat", 32'(os(u)), 32'(es));
      chk("in_ready_in_out", 32'(rdy(u)), 32'd0);
      held = od(u);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("bp_data_stable", od(u), held);
         chk("bp_valid_held", 32'(ov(u)), 32'd1);
         chk("bp_in_ready_low", 32'(rdy(u)), 32'd0);
      end
      if (u == 0) b0.out_ready = 1'b1;
      else        b1.out_ready = 1'b1;
      @(posedge clk); #1;
      b0.out_ready = 1'b0;
      b1.out_ready = 1'b0;
      chk("out_valid_drop", 32'(ov(u)), 32'd0);
      chk("in_ready_return", 32'(rdy(u)), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int bsy;
      int pend;
      b0.in_data = '0; b0.in_valid = 1'b0; b0.coef_we = 1'b0;
      b0.coef_addr = '0; b0.coef_data = '0; b0.out_ready = 1'b0;
      b1.in_data = '0; b1.in_valid = 1'b0; b1.coef_we = 1'b0;
      b1.coef_addr = '0; b1.coef_data = '0; b1.out_ready = 1'b0;
      model_reset();

      // Reset values
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
         chk("rst_in_ready", 32'(rdy(u)), 32'd1);
         chk("rst_coef_busy", 32'(cbusy(u)), 32'd0);
         chk("rst_out_valid", 32'(ov(u)), 32'd0);
         chk("rst_out_data", od(u), 32'd0);
         chk("rst_out_sat", 32'(os(u)), 32'd0);
      end

      // Impulse response on the DEC=1 instance: expect 1,2,3,4,0
      for (int k = 0; k < int'(TAPS); k++) wcoef(1, k, k + 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         send(1, (i == 0) ? 1 : 0);
         get(1, 0, lat, bsy);
      end

      // Full-scale input with max coefficients overflows the 8-bit output
      for (int k = 0; k < int'(TAPS); k++) wcoef(1, k, 511, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(1, 127);
         get(1, 0, lat, bsy);
      end

      // Random traffic on the DEC=1 instance
      for (int k = 0; k < int'(TAPS); k++) wcoef(1, k, int'($urandom_range(0, 1023)) - 512, 1'b1);
      for (int i = 0; i < 8; i++) begin
         send(1, int'($urandom_range(0, 255)) - 128);
         get(1, 0, lat, bsy);
      end

      // Decimation by 4 with unit taps: ramp 1..8 gives 10 then 26
      for (int k = 0; k < int'(TAPS); k++) wcoef(0, k, 1, 1'b1);
      for (int blk = 0; blk < 2; blk++) begin
         for (int i = 1; i <= 3; i++) begin
            send(0, blk * 4 + i);
            chk("no_early_output", 32'(ov(0)), 32'd0);
         end
         send(0, blk * 4 + 4);
         get(0, 0, lat, bsy);
         chk("latency", 32'(lat), 32'(TAPS + 1));
         chk("coef_busy_cycles", 32'(bsy), 32'(TAPS));
      end

      // Backpressure: a pending sample waits out the stalled output
      for (int k = 0; k < int'(TAPS); k++) wcoef(0, k, int'($urandom_range(0, 1023)) - 512, 1'b1);
      for (int i = 0; i < 4; i++) send(0, int'($urandom_range(0, 255)) - 128);
      pend = int'($urandom_range(0, 255)) - 128;
      b0.in_data  = WIN'(pend);
      b0.in_valid = 1'b1;
      get(0, 10, lat, bsy);
      send(0, pend);
      for (int i = 0; i < 3; i++) send(0, int'($urandom_range(0, 255)) - 128);
      get(0, 0, lat, bsy);

      // Coefficient write during MAC is dropped; the same write in IDLE lands
      for (int i = 0; i < 4; i++) send(0, int'($urandom_range(1, 100)));
      chk("busy_at_write", 32'(cbusy(0)), 32'd1);
      wcoef(0, 0, 7, 1'b0);
      get(0, 0, lat, bsy);
      wcoef(0, 0, 7, 1'b1);
      for (int i = 0; i < 4; i++) send(0, int'($urandom_range(1, 100)));
      get(0, 0, lat, bsy);

      // Coefficient write and sample accept on the same edge
      b0.coef_we   = 1'b1;
      b0.coef_addr = AW'(1);
      b0.coef_data = WCOEF'(-3);
      send(0, 55);
      b0.coef_we = 1'b0;
      hc[0][1] = -3;
      for (int i = 0; i < 3; i++) send(0, int'($urandom_range(0, 255)) - 128);
      get(0, 0, lat, bsy);

      // Random traffic on the decimating instance
      for (int k = 0; k < int'(TAPS); k++) wcoef(0, k, int'($urandom_range(0, 1023)) - 512, 1'b1);
      for (int i = 0; i < 16; i++) begin
         send(0, int'($urandom_range(0, 255)) - 128);
         if (exp0.size() > 0) get(0, 0, lat, bsy);
      end

      // Reset during MAC aborts the pass and clears coefficients
      for (int i = 0; i < 4; i++) send(0, int'($urandom_range(1, 100)));
      @(posedge clk); #1;
      chk("in_mac_before_reset", 32'(cbusy(0)), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_out_valid", 32'(ov(0)), 32'd0);
      chk("abort_in_ready", 32'(rdy(0)), 32'd1);
      chk("abort_coef_busy", 32'(cbusy(0)), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      chk("post_reset_out_valid", 32'(ov(0)), 32'd0);
      for (int i = 0; i < 4; i++) send(0, (i == 0) ? 1 : 0);
      get(0, 0, lat, bsy);
      chk("post_reset_latency", 32'(lat), 32'(TAPS + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
